// File: rtl/ser_tx_ctrl_pkg.sv
// ser_pkg: shared types for the serial transmit controller slice.
//   state_t : controller FSM state (IDLE, SHIFT)
//   byte_t  : one transmitted byte
package ser_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/ser_tx_ctrl_if.sv
// ser_tx_ctrl_if: byte input handshake of the serial transmit controller.
//   in_data  : byte to transmit, MSB first (master -> slave)
//   in_valid : in_data valid                (master -> slave)
//   in_ready : holding register empty       (slave -> master)
// A byte is accepted on the posedge clk where in_valid && in_ready.
interface ser_tx_ctrl_if;
  import ser_pkg::*;

  byte_t in_data;
  logic  in_valid;
  logic  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ser_clk_gen.sv
// ser_clk_gen: divides clk down to the free-running serial clock.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset (clk_ser forced low)
//   clk_ser  : serial clock, period 2*CLK_DIV clk cycles, 50% duty
//   rise_evt : high in the cycle whose closing posedge takes clk_ser 0->1
//   fall_evt : high in the cycle whose closing posedge takes clk_ser 1->0
module ser_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic clk_ser,
  output logic rise_evt,
  output logic fall_evt
);

  localparam logic [7:0] TERM_CNT = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       term;

  assign term = (div_cnt == TERM_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      clk_ser <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      clk_ser <= ~clk_ser;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Strobes lead the clk_ser edge by one cycle so controller registers
  // update on the same posedge clk that toggles clk_ser.
  assign rise_evt = term & ~clk_ser;
  assign fall_evt = term &  clk_ser;

endmodule

// File: rtl/ser_tx_ctrl.sv
// ser_tx_ctrl: feeds bytes to a downstream parallel-load serializer.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   in_if      : byte handshake (in_data / in_valid / in_ready)
//   clk_ser    : free-running serial clock to the serializer
//   clk_par    : active-low parallel load strobe, low across one clk_ser fall
//   data_par   : parallel byte, held until the next load
//   busy       : byte in flight or holding register full
//   bytes_sent : bytes loaded into the serializer, wraps at 16 bits
// The serializer launches bits on clk_ser falls; DEFAULT_VAL documents the
// line level it shifts in while no byte is loaded.
module ser_tx_ctrl
  import ser_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int DEFAULT_VAL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  ser_tx_ctrl_if.slave     in_if,
  output logic             clk_ser,
  output logic             clk_par,
  output byte_t            data_par,
  output logic             busy,
  output logic [CNT_W-1:0] bytes_sent
);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 255 || DEFAULT_VAL < 0 || DEFAULT_VAL > 1) begin : g_bad_param
      $error("ser_tx_ctrl: CLK_DIV must be 1..255 and DEFAULT_VAL 0 or 1");
    end
  endgenerate

  logic rise_evt;
  logic fall_evt;

  ser_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_ser  (clk_ser),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  state_t           state_q,     state_d;
  logic [2:0]       bit_cnt_q,   bit_cnt_d;
  logic             hold_full_q, hold_full_d;
  byte_t            hold_q;
  logic             clk_par_d;
  byte_t            data_par_d;
  logic             busy_d;
  logic [CNT_W-1:0] sent_cnt_q;

  logic accept;
  logic load_slot;
  logic do_load;

  assign in_if.in_ready = ~hold_full_q;
  assign accept         = in_if.in_valid & ~hold_full_q;

  // A new byte may only start on a rise, either from idle or right after
  // the eighth bit of the current byte has been launched.
  assign load_slot = rise_evt &
                     ((state_q == IDLE) || ((state_q == SHIFT) && (bit_cnt_q == 3'd7)));
  assign do_load   = load_slot & hold_full_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    clk_par_d   = clk_par;
    data_par_d  = data_par;
    hold_full_d = hold_full_q;

    if (do_load) begin
      state_d    = SHIFT;
      bit_cnt_d  = 3'd0;
      clk_par_d  = 1'b0;
      data_par_d = hold_q;
    end else if (rise_evt) begin
      clk_par_d = 1'b1;
      if (load_slot) begin
        state_d = IDLE;
      end
    end else if (fall_evt && (state_q == SHIFT) && clk_par && (bit_cnt_q != 3'd7)) begin
      // The fall under a low clk_par is the load itself, not a shift.
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    if (accept) begin
      hold_full_d = 1'b1;
    end else if (do_load) begin
      hold_full_d = 1'b0;
    end

    busy_d = (state_d == SHIFT) || hold_full_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      hold_full_q <= 1'b0;
      clk_par     <= 1'b1;
      data_par    <= '0;
      busy        <= 1'b0;
      sent_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_full_q <= hold_full_d;
      clk_par     <= clk_par_d;
      data_par    <= data_par_d;
      busy        <= busy_d;
      if (do_load) begin
        sent_cnt_q <= sent_cnt_q + 16'd1;
      end
    end
  end

  // Holding data needs no reset: it is only read while hold_full_q is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q <= in_if.in_data;
    end
  end

  assign bytes_sent = sent_cnt_q;

endmodule

// File: doc/ser_tx_ctrl.md
SER_TX_CTRL -- requirements
Module: ser_tx_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2, clk cycles per clk_ser half-period (legal 1..255).
REQ-002 Parameter DEFAULT_VAL, default 1, idle line level the downstream shifter fills with (informational; not used by logic).
REQ-003 clk  in  1  system clock; all state updates on posedge clk.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_data  in  8  byte to transmit, MSB first.
REQ-006 in_valid  in  1  in_data valid.
REQ-007 in_ready  out  1  holding register empty; byte accepted when in_valid && in_ready on posedge clk.
REQ-008 clk_ser  out  1  free-running serial clock to the serializer.
REQ-009 clk_par  out  1  active-low parallel load strobe to the serializer.
REQ-010 data_par  out  8  parallel byte to the serializer.
REQ-011 busy  out  1  byte in flight or holding register full.
REQ-012 bytes_sent  out  16  count of bytes loaded into the serializer, wraps at 65535->0.

Function
REQ-013 Divider counts 0..CLK_DIV-1; at terminal count clk_ser toggles and counter returns to 0, giving clk_ser period 2*CLK_DIV clk cycles, 50% duty.
REQ-014 Toggle 0->1 is a "rise event", 1->0 a "fall event"; all outputs are registers, none combinational from inputs except in_ready = !hold_full.
REQ-015 Holding register: one byte; loaded on accept; cleared when transferred to data_par; accept and transfer in the same cycle leave it full with the new byte.
REQ-016 FSM states IDLE, SHIFT; bit_cnt 3 bits.
REQ-017 Load slot exists at a rise event when state is IDLE, or state is SHIFT with bit_cnt==7.
REQ-018 At a load slot with hold_full: data_par <= hold, clk_par <= 0, bit_cnt <= 0, state <= SHIFT, bytes_sent increments, all in the cycle clk_ser rises.
REQ-019 At a load slot without hold_full: clk_par stays 1, state <= IDLE.
REQ-020 clk_par returns to 1 at the next rise event, so it is low across exactly one fall event; data_par is held constant until the next load.
REQ-021 In SHIFT each fall event with clk_par==1 increments bit_cnt; bit_cnt saturates at 7.
REQ-022 Back-to-back bytes: loads occur every 8 clk_ser periods with no idle bits; gap bits (IDLE) are shifter fill (DEFAULT_VAL).
REQ-023 A byte presented mid-frame waits in the holding register for the next load slot; in_ready stays 0 meanwhile.
REQ-024 busy = (state==SHIFT) || hold_full, registered.

Reset
REQ-025 While reset_n==0: clk_ser=0, clk_par=1, data_par=8'h00, divider=0, bit_cnt=0, state=IDLE, hold empty (in_ready=1), busy=0, bytes_sent=0.
REQ-026 Reset mid-frame discards the in-flight and held bytes; clk_par stays 1 so the forced clk_ser fall only shifts fill data.
REQ-027 First rise event after release occurs CLK_DIV cycles after the first posedge clk with reset_n==1.

Structure
REQ-028 Package ser_pkg holds the state enum (IDLE, SHIFT) and the byte typedef.
REQ-029 Sub-module ser_clk_gen (divider, clk_ser register, rise/fall event strobes); ser_tx_ctrl instantiates it once.

Verification (CLK_DIV=2, downstream serializer model with negedge launch, default 1)
REQ-030 Single byte 8'hA5 after reset -> clk_par low exactly 4 clk cycles; serial line shows 1,0,1,0,0,1,0,1 then idle 1s; bytes_sent=1.
REQ-031 Continuous in_valid with 8'h00, 8'hFF, 8'h3C -> loads 32 clk cycles apart, 24 contiguous bits with no gap; in_ready low while hold full.
REQ-032 in_valid held 0 for 100 cycles -> clk_par constantly 1, busy=0, serial line all 1s, clk_ser period 4.
REQ-033 reset_n pulsed low at bit 3 of 8'h81 with hold full -> all REQ-025 values immediately; no load after release until new accept.
REQ-034 Accept coinciding with load slot transfer (hold full, new in_valid) -> old byte to data_par, new byte held, no byte lost or duplicated.
REQ-035 65536 bytes sent -> bytes_sent wraps to 0.
